nlfsr_stream_checker: RTL and testbench

Receive-side checker for the 16-bit NLFSR test bitstream: consumes the serial output of the NLFSR generator and its advance strobe, self-synchronises a local 16-bit history to the stream, then predicts every following bit and counts mismatches. It sits directly downstream of the generator, either on-chip in loopback or on the test board's capture side. It gives a single lock flag and a saturating error count for factory-test pass/fail.

---
 rtl/nlfsr_pkg.sv | 21 ++
 rtl/nlfsr_stream_checker.sv | 135 +++++++++++++
 tb/tb_nlfsr_stream_checker.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nlfsr_pkg.sv
// Shared NLFSR definitions: width, seed, checker states
// and the feedback function used by generator and checker.
package nlfsr_pkg;

  localparam int NLFSR_W = 16;
  localparam logic [NLFSR_W-1:0] NLFSR_INIT = 16'h0001;

  typedef enum logic [1:0] {
    SYNC,
    VERIFY,
    LOCKED
  } state_t;

  function automatic logic nlfsr_next_bit(
    input logic [NLFSR_W-1:0] hist
  );
    return hist[0] ^ hist[8] ^ hist[15]
         ^ (hist[1] & hist[2] & hist[3] & hist[9]);
  endfunction

endpackage

// File: rtl/nlfsr_stream_checker.sv
// NLFSR stream checker: syncs on bit_in/bit_valid, flags lock,
// pulses err_pulse and counts err_cnt (saturating, err_clr clears).
module nlfsr_stream_checker
  import nlfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 32,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_COUNT - 1);

  state_t               state;
  state_t               state_nxt;
  logic [NLFSR_W-1:0]   hist;
  logic [NLFSR_W-1:0]   hist_nxt;
  logic [3:0]           fill_cnt;
  logic [RW-1:0]        run_cnt;
  logic [MW-1:0]        miss_cnt;
  logic                 pred;
  logic                 mis;
  logic                 cnt_err;

  // A zero window can never come from the generator.
  assign pred = nlfsr_next_bit(hist);
  assign mis  = (hist == '0) | (bit_in ^ pred);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bit_valid) begin
      unique case (state)
        SYNC:
          if (fill_cnt == 4'd15)
            state_nxt = VERIFY;
        VERIFY:
          if (!mis && run_cnt == RUN_LAST)
            state_nxt = LOCKED;
        LOCKED:
          if (mis && miss_cnt == MISS_LAST)
            state_nxt = SYNC;
        default:
          state_nxt = SYNC;
      endcase
    end
  end

  // Flywheel: once locked, the prediction is shifted in
  // so one corrupted bit is counted only once.
  always_comb begin
    hist_nxt = hist;
    cnt_err  = 1'b0;
    if (bit_valid) begin
      unique case (1'b1)
        (state == LOCKED): begin
          hist_nxt = {pred, hist[NLFSR_W-1:1]};
          cnt_err  = mis;
        end
        default:
          hist_nxt = {bit_in, hist[NLFSR_W-1:1]};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist      <= '0;
      fill_cnt  <= '0;
      run_cnt   <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= cnt_err;
      locked    <= (state_nxt == LOCKED);
      hist      <= hist_nxt;
      if (bit_valid) begin
        unique case (state)
          SYNC: begin
            fill_cnt <= fill_cnt + 4'd1;
            run_cnt  <= '0;
            miss_cnt <= '0;
          end
          VERIFY: begin
            fill_cnt <= '0;
            miss_cnt <= '0;
            if (mis || run_cnt == RUN_LAST)
              run_cnt <= '0;
            else
              run_cnt <= run_cnt + 1'b1;
          end
          LOCKED: begin
            fill_cnt <= '0;
            run_cnt  <= '0;
            if (!mis || miss_cnt == MISS_LAST)
              miss_cnt <= '0;
            else
              miss_cnt <= miss_cnt + 1'b1;
          end
          default: begin
            fill_cnt <= '0;
            run_cnt  <= '0;
            miss_cnt <= '0;
          end
        endcase
      end
      if (cnt_err) begin
        if (err_clr)
          err_cnt <= ERR_W'(1);
        else if (!(&err_cnt))
          err_cnt <= err_cnt + 1'b1;
      end else if (err_clr) begin
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nlfsr_stream_checker.sv
// Scoreboard bench for nlfsr_stream_checker: a queue-based
// reference model predicts outputs of a default and an ERR_W=4 DUT.
module tb_nlfsr_stream_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic        locked4, pulse4;
  logic [3:0]  err_cnt4;

  always #5 clk = ~clk;

  nlfsr_stream_checker dut (
    .clk(clk), .rst(rst), .bit_in(bit_in),
    .bit_valid(bit_valid), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse),
    .err_cnt(err_cnt)
  );

  nlfsr_stream_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .bit_in(bit_in),
    .bit_valid(bit_valid), .err_clr(err_clr),
    .locked(locked4), .err_pulse(pulse4),
    .err_cnt(err_cnt4)
  );

  typedef struct {
    bit lk;
    bit pl;
    int e16;
    int e4;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: 0=sync 1=verify 2=locked
  int m_state, m_fill, m_run, m_miss, m_e16, m_e4;
  bit win[$];
  bit gen[$];

  function automatic bit rule(bit w[$]);
    return w[0] ^ w[8] ^ w[15]
         ^ (w[1] & w[2] & w[3] & w[9]);
  endfunction

  function automatic void gen_reset();
    gen.delete();
    for (int i = 0; i < 16; i++) gen.push_back(i == 0);
  endfunction

  function automatic bit gen_next();
    bit o = gen[0];
    gen.push_back(rule(gen));
    void'(gen.pop_front());
    return o;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_fill = 0; m_run = 0; m_miss = 0;
    m_e16 = 0; m_e4 = 0;
    win.delete();
    for (int i = 0; i < 16; i++) win.push_back(1'b0);
  endfunction

  function automatic exp_t model_step(bit b, bit v, bit c);
    exp_t e;
    bit p, z, mis, pl;
    pl = 1'b0;
    p = rule(win);
    z = 1'b1;
    foreach (win[i]) if (win[i]) z = 1'b0;
    mis = z || (b != p);
    if (v) begin
      if (m_state == 0) begin
        win.push_back(b); void'(win.pop_front());
        m_fill++;
        if (m_fill == 16) begin
          m_state = 1; m_fill = 0; m_run = 0;
        end
      end else if (m_state == 1) begin
        win.push_back(b); void'(win.pop_front());
        if (mis) m_run = 0;
        else begin
          m_run++;
          if (m_run == 32) begin
            m_state = 2; m_run = 0; m_miss = 0;
          end
        end
      end else begin
        win.push_back(p); void'(win.pop_front());
        if (mis) begin
          pl = 1'b1;
          m_miss++;
          if (m_miss == 4) begin
            m_state = 0; m_fill = 0; m_miss = 0;
          end
        end else m_miss = 0;
      end
    end
    if (pl) begin
      m_e16 = c ? 1 : (m_e16 < 65535 ? m_e16 + 1 : m_e16);
      m_e4  = c ? 1 : (m_e4 < 15 ? m_e4 + 1 : m_e4);
    end else if (c) begin
      m_e16 = 0; m_e4 = 0;
    end
    e.lk = (m_state == 2);
    e.pl = pl;
    e.e16 = m_e16;
    e.e4 = m_e4;
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic drive(bit b, bit v, bit c, bit r);
    exp_t e;
    @(negedge clk);
    rst = r;
    bit_in = b;
    bit_valid = v;
    err_clr = c;
    if (r) begin
      model_reset();
      e = '{0, 0, 0, 0};
    end else begin
      e = model_step(b, v, c);
    end
    sbq.push_back(e);
  endtask

  // period>1: valid every period cycles; rgap: random gaps
  task automatic run_stream(int nvalid, int period, bit rgap,
                            int flip_at, bit zero, bit rclr);
    int k = 0;
    int cyc = 0;
    bit v, b, c;
    while (k < nvalid) begin
      if (rgap) v = ($urandom_range(0, 3) != 0);
      else v = ((cyc % period) == 0);
      c = rclr && ($urandom_range(0, 63) == 0);
      cyc++;
      if (v) begin
        b = gen_next();
        k++;
        if (k == flip_at) b = ~b;
        if (zero) b = 1'b0;
        drive(b, 1'b1, c, 1'b0);
      end else begin
        drive(1'($urandom_range(0, 1)), 1'b0, c, 1'b0);
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("locked", int'(locked), int'(e.lk));
        chk("err_pulse", int'(err_pulse), int'(e.pl));
        chk("err_cnt", int'(err_cnt), e.e16);
        chk("err_cnt4", int'(err_cnt4), e.e4);
        chk("pulse4", int'(pulse4), int'(e.pl));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit b;
    model_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);

    gen_reset();
    run_stream(1000, 1, 1'b0, 0, 1'b0, 1'b1);

    drive(1'b0, 1'b0, 1'b0, 1'b1);
    gen_reset();
    run_stream(200, 3, 1'b0, 0, 1'b0, 1'b0);

    drive(1'b0, 1'b0, 1'b0, 1'b1);
    gen_reset();
    run_stream(300, 1, 1'b1, 200, 1'b0, 1'b0);

    run_stream(60, 1, 1'b0, 0, 1'b1, 1'b0);

    drive(1'b0, 1'b0, 1'b0, 1'b1);
    gen_reset();
    run_stream(60, 1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      b = gen_next();
      drive(~b, 1'b1, 1'b0, 1'b0);
      b = gen_next();
      drive(b, 1'b1, 1'b0, 1'b0);
    end
    b = gen_next();
    drive(~b, 1'b1, 1'b1, 1'b0);
    b = gen_next();
    drive(b, 1'b1, 1'b0, 1'b0);
    b = gen_next();
    drive(b, 1'b1, 1'b1, 1'b0);
    b = gen_next();
    drive(~b, 1'b1, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_locked", int'(locked), 0);
    chk("async_err_pulse", int'(err_pulse), 0);
    chk("async_err_cnt", int'(err_cnt), 0);
    chk("async_err_cnt4", int'(err_cnt4), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    gen_reset();
    run_stream(60, 1, 1'b0, 0, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    chk("drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
